// File: rtl/keypad_scanner_pkg.sv
// Shared definitions for the keypad scanner.
// Contents:
//   state_t        - scanner FSM states (SCAN, DEBOUNCE, HELD)
//   key_map        - (row, column) to hex code table for the 4x4 keypad
//   col_drive_n    - active-low one-hot column drive pattern
//   lowest_low_row - index of the lowest-numbered asserted (low) row
package keypad_scanner_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    // Keypad legend, row-major:
    //   r0 = 1 2 3 A
    //   r1 = 4 5 6 B
    //   r2 = 7 8 9 C
    //   r3 = E 0 F D   (E = '*', F = '#')
    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'd0:    code = 4'h1;
            4'd1:    code = 4'h2;
            4'd2:    code = 4'h3;
            4'd3:    code = 4'hA;
            4'd4:    code = 4'h4;
            4'd5:    code = 4'h5;
            4'd6:    code = 4'h6;
            4'd7:    code = 4'hB;
            4'd8:    code = 4'h7;
            4'd9:    code = 4'h8;
            4'd10:   code = 4'h9;
            4'd11:   code = 4'hC;
            4'd12:   code = 4'hE;
            4'd13:   code = 4'h0;
            4'd14:   code = 4'hF;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    function automatic logic [3:0] col_drive_n(input logic [1:0] col);
        return ~(4'b0001 << col);
    endfunction

    // Lowest-index row wins when several keys in one column are down.
    function automatic logic [1:0] lowest_low_row(input logic [3:0] rows_n);
        logic [1:0] r;
        if (!rows_n[0])      r = 2'd0;
        else if (!rows_n[1]) r = 2'd1;
        else if (!rows_n[2]) r = 2'd2;
        else if (!rows_n[3]) r = 2'd3;
        else                 r = 2'd0;
        return r;
    endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// Two-flop synchronizer for an asynchronous bus.
// Resets to all ones because the keypad rows idle high through pull-ups.
// Ports:
//   clk   - destination clock
//   reset - asynchronous, active-high
//   d     - asynchronous input bus
//   q     - synchronized output bus (two clk of latency)
module sync2 #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one column low per slot, samples the
// synchronized rows at the end of each slot, debounces a press over
// DEBOUNCE_SCANS consecutive samples and emits the hex code with a one-cycle
// key_valid strobe. The column stays frozen while a key is held so no other
// key can be reported until the release has been debounced.
// Ports:
//   clk       - system clock, rising edge
//   reset     - asynchronous, active-high; clears all state
//   row_n     - keypad rows, active-low, asynchronous to clk
//   col_n     - keypad column drive, active-low one-hot while scanning
//   key_code  - hex code of the last accepted key
//   key_valid - one-cycle pulse when a press is accepted
//   key_held  - high from key_valid until the release is accepted
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 4,
    parameter int unsigned DEBOUNCE_SCANS = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int unsigned SLOT_W = $clog2(SCAN_DIV);
    localparam int unsigned CNT_W  = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_SCANS - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEBOUNCE_SCANS);

    logic [3:0]        row_s;
    logic [SLOT_W-1:0] slot_cnt;
    state_t            state;
    logic [1:0]        col;
    logic [1:0]        cand_row;
    logic [1:0]        cand_col;
    logic [CNT_W-1:0]  deb_cnt;
    logic [CNT_W-1:0]  rel_cnt;

    logic       slot_end;
    logic       any_low;
    logic [1:0] low_row;
    logic [1:0] drive_col;

    sync2 #(.WIDTH(4)) u_row_sync (
        .clk   (clk),
        .reset (reset),
        .d     (row_n),
        .q     (row_s)
    );

    always_comb begin
        slot_end  = (slot_cnt == SLOT_LAST);
        any_low   = (row_s != 4'b1111);
        low_row   = lowest_low_row(row_s);
        drive_col = (state == SCAN) ? col : cand_col;
    end

    // col_n is registered: by default it re-asserts the current drive column,
    // and branches that move to a new column on the sample edge override it so
    // the new column is on the pins for the full next slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_cnt  <= '0;
            state     <= SCAN;
            col       <= '0;
            cand_row  <= '0;
            cand_col  <= '0;
            deb_cnt   <= '0;
            rel_cnt   <= '0;
            col_n     <= 4'b1111;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            col_n     <= col_drive_n(drive_col);
            slot_cnt  <= slot_end ? '0 : slot_cnt + 1'b1;

            if (slot_end) begin
                case (state)
                    SCAN: begin
                        if (!any_low) begin
                            col   <= col + 2'd1;
                            col_n <= col_drive_n(col + 2'd1);
                        end else begin
                            cand_row <= low_row;
                            cand_col <= col;
                            if (DEBOUNCE_SCANS == 1) begin
                                key_code  <= key_map(low_row, col);
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                deb_cnt   <= CNT_MAX;
                                rel_cnt   <= '0;
                                state     <= HELD;
                            end else begin
                                deb_cnt <= CNT_W'(1);
                                state   <= DEBOUNCE;
                            end
                        end
                    end

                    DEBOUNCE: begin
                        if (any_low && (low_row == cand_row)) begin
                            if (deb_cnt >= CNT_LAST) begin
                                key_code  <= key_map(cand_row, cand_col);
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                deb_cnt   <= CNT_MAX;
                                rel_cnt   <= '0;
                                state     <= HELD;
                            end else begin
                                deb_cnt <= deb_cnt + 1'b1;
                            end
                        end else begin
                            deb_cnt <= '0;
                            col     <= cand_col + 2'd1;
                            col_n   <= col_drive_n(cand_col + 2'd1);
                            state   <= SCAN;
                        end
                    end

                    HELD: begin
                        if (any_low) begin
                            rel_cnt <= '0;
                        end else if (rel_cnt >= CNT_LAST) begin
                            rel_cnt  <= '0;
                            deb_cnt  <= '0;
                            key_held <= 1'b0;
                            col      <= cand_col + 2'd1;
                            col_n    <= col_drive_n(cand_col + 2'd1);
                            state    <= SCAN;
                        end else begin
                            rel_cnt <= rel_cnt + 1'b1;
                        end
                    end

                    default: begin
                        state <= SCAN;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed, self-checking bench for keypad_scanner (SCAN_DIV=4,
// DEBOUNCE_SCANS=3). The keypad matrix is modelled combinationally from
// col_n and the set of pressed keys; expected key codes are queued when a
// press is driven and popped whenever key_valid is observed.
`timescale 1ns/1ps
module tb_keypad_scanner;

    logic       clk;
    logic       reset;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [15:0] keys;          // keys[r*4+c] = 1 while key (r,c) is pressed
    logic [3:0]  exp_q[$];
    int          tests;
    int          failed;
    int          pulses;

    keypad_scanner #(
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .row_n     (row_n),
        .col_n     (col_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        row_n = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col_n[c])
                    row_n[r] = 1'b0;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n clocks, sampling 1 ns after each rising edge; every key_valid
    // seen must match the head of the expectation queue.
    task automatic tick(input int n);
        logic [3:0] e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (key_valid === 1'b1) begin
                pulses++;
                check("pulse_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("key_code", 32'(key_code), 32'(e));
                end
            end
        end
    endtask

    task automatic wait_valid(input int budget, input string tag, output int n);
        int start;
        start = pulses;
        n = 0;
        while (pulses == start && n < budget) begin
            tick(1);
            n++;
        end
        check({tag, "_valid_seen"}, 32'(pulses != start), 32'd1);
    endtask

    task automatic wait_release(input int budget, input string tag, output int n);
        n = 0;
        while (key_held === 1'b1 && n < budget) begin
            tick(1);
            n++;
        end
        check({tag, "_release_seen"}, 32'(key_held), 32'd0);
    endtask

    task automatic wait_col(input logic [3:0] pat, input int budget, input string tag);
        int n;
        n = 0;
        while (col_n !== pat && n < budget) begin
            tick(1);
            n++;
        end
        check({tag, "_col_reached"}, 32'(col_n), 32'(pat));
    endtask

    initial begin
        int         n;
        int         p0;
        logic [3:0] e;

        tests  = 0;
        failed = 0;
        pulses = 0;
        keys   = '0;
        reset  = 1'b0;
        #2 reset = 1'b1;

        // 1: reset values, then idle scan pattern
        tick(3);
        check("rst_col_n", 32'(col_n), 32'hF);
        check("rst_key_code", 32'(key_code), 32'h0);
        check("rst_key_valid", 32'(key_valid), 32'h0);
        check("rst_key_held", 32'(key_held), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        // First slot after reset is one clk short: col_n is registered from
        // the first edge, the column advances on every 4th edge.
        for (int k = 1; k <= 20; k++) begin
            tick(1);
            e = 4'b1111;
            e[(k < 4) ? 0 : ((k / 4) % 4)] = 1'b0;
            check("idle_col_n", 32'(col_n), 32'(e));
        end
        check("idle_pulses", 32'(pulses), 32'd0);
        check("idle_key_code", 32'(key_code), 32'h0);

        // 2: press (r1,c2), hold 100 clk
        p0 = pulses;
        exp_q.push_back(4'h6);
        keys[1*4+2] = 1'b1;
        wait_valid(60, "t2", n);
        check("t2_latency_ok", 32'(n <= 26), 32'd1);
        check("t2_key_held", 32'(key_held), 32'd1);
        tick(100);
        check("t2_pulses", 32'(pulses - p0), 32'd1);
        check("t2_key_code", 32'(key_code), 32'h6);
        check("t2_key_held_after", 32'(key_held), 32'd1);
        check("t2_col_frozen", 32'(col_n), 32'b1011);

        // 3: release; key_held falls on the third consecutive all-high
        // sample, which lands 11..14 clk after the release
        keys = '0;
        wait_release(40, "t3", n);
        check("t3_release_window", 32'(n >= 11 && n <= 14), 32'd1);
        check("t3_resume_col", 32'(col_n), 32'b0111);
        tick(4);
        check("t3_next_col", 32'(col_n), 32'b1110);

        // 4: bouncing (r3,c0) never accepted, then a stable press
        p0 = pulses;
        for (int i = 0; i < 5; i++) begin
            keys[3*4+0] = 1'b1;
            tick(6);
            keys[3*4+0] = 1'b0;
            tick(6);
        end
        tick(30);
        check("t4_bounce_pulses", 32'(pulses - p0), 32'd0);
        exp_q.push_back(4'hE);
        keys[3*4+0] = 1'b1;
        wait_valid(60, "t4", n);
        check("t4_key_held", 32'(key_held), 32'd1);
        keys = '0;
        wait_release(40, "t4", n);
        check("t4_resume_col", 32'(col_n), 32'b1101);
        check("t4_pulses", 32'(pulses - p0), 32'd1);

        // 5: two keys in column 3 -> lowest row wins; a key in another
        // column while held is ignored
        p0 = pulses;
        exp_q.push_back(4'hA);
        keys[0*4+3] = 1'b1;
        keys[2*4+3] = 1'b1;
        wait_valid(60, "t5", n);
        check("t5_col_frozen", 32'(col_n), 32'b0111);
        tick(8);
        keys[2*4+1] = 1'b1;
        tick(60);
        check("t5_still_held", 32'(key_held), 32'd1);
        check("t5_key_code", 32'(key_code), 32'hA);
        keys = '0;
        wait_release(40, "t5", n);
        tick(40);
        check("t5_pulses", 32'(pulses - p0), 32'd1);

        // 6: reset while (r3,c1) is being debounced
        p0 = pulses;
        wait_col(4'b1110, 40, "t6_pre");
        keys[3*4+1] = 1'b1;
        wait_col(4'b1101, 40, "t6");
        tick(6);
        reset = 1'b1;
        #1;
        check("t6_rst_col_n", 32'(col_n), 32'hF);
        check("t6_rst_key_held", 32'(key_held), 32'd0);
        check("t6_rst_key_valid", 32'(key_valid), 32'd0);
        check("t6_rst_key_code", 32'(key_code), 32'h0);
        tick(20);
        check("t6_in_rst_col_n", 32'(col_n), 32'hF);
        check("t6_in_rst_pulses", 32'(pulses - p0), 32'd0);
        exp_q.push_back(4'h0);
        @(negedge clk);
        reset = 1'b0;
        wait_valid(60, "t6", n);
        check("t6_key_held", 32'(key_held), 32'd1);
        check("t6_col_frozen", 32'(col_n), 32'b1101);
        keys = '0;
        wait_release(40, "t6", n);
        tick(20);
        check("t6_pulses", 32'(pulses - p0), 32'd1);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
